bus_cycle_master: RTL
=====================

Name: bus_cycle_master

Overview:
- Bus initiator that runs single read/write cycles on the 20-bit system address bus that feeds the chip-select glue decoder (ROM / RAM #1-#4 / VRAM map).
- Accepts one request at a time from a core-side valid/ready port. It generates address, write data and active-low strobes, with per-region wait states, and returns read data and status.
- Sits between the processor-side core and the shared memory bus. It is the initiator end of the address/chip-select interface.

Parameters:
- ROM_WS, 2, extra strobe cycles for ROM accesses (0x00000-0x03FFF).
- RAM_WS, 0, extra strobe cycles for RAM accesses (0x04000-0xEFFFF).
- VRAM_WS, 1, extra strobe cycles for VRAM accesses (0xF0000-0xFFFFF).
- DW, 8, data bus width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  core request present.
- req_ready  output  1  block can accept a request.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  20  request address.
- req_wdata  input  DW  write data.
- rsp_valid  output  1  one-cycle response strobe.
- rsp_rdata  output  DW  captured read data; valid while rsp_valid is high.
- rsp_err  output  1  error flag (write to ROM); valid while rsp_valid is high.
- bus_addr  output  20  address to the decoder and memories.
- bus_wdata  output  DW  write data to the bus.
- bus_rdata  input  DW  read data from the bus.
- bus_oe_n  output  1  read strobe, active low.
- bus_we_n  output  1  write strobe, active low.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state IDLE, bus_addr=0, bus_wdata=0, bus_oe_n=1, bus_we_n=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- req_ready = (state==IDLE), combinational. A transfer is accepted when req_valid & req_ready at a rising edge.
- On accept, latch req_addr, req_we and req_wdata into bus_addr, the direction register and bus_wdata.
- Decode the latched address into a region using the system map above and load the wait counter with that region's WS.
- IDLE: wait for accept.
  - Read, or write to RAM/VRAM -> SETUP.
  - Write to ROM -> DONE with rsp_err=1, and no strobe is ever asserted.
- SETUP (1 cycle): address and data stable, strobes high -> STROBE.
- STROBE (WS+1 cycles):
  - bus_oe_n=0 for a read, bus_we_n=0 for a write.
  - The counter decrements each cycle. When it reaches 0: capture bus_rdata into rsp_rdata on a read, then go to HOLD.
- HOLD (1 cycle): strobes high, address and data held -> DONE.
- DONE (1 cycle): rsp_valid=1 and rsp_err valid -> IDLE. rsp_rdata holds its value until the next read capture.
- Latency, accept edge to rsp_valid cycle:
  - RAM (WS=0): 4 cycles.
  - ROM read (WS=2): 6 cycles.
  - VRAM (WS=1): 5 cycles.
  - ROM write error: 1 cycle.
- bus_addr and bus_wdata change only on accept. They hold their last value while IDLE.
- bus_oe_n and bus_we_n are never low at the same time.
- Strobes are registered outputs, so they are glitch-free.
- req_valid is ignored outside IDLE. The core must keep its request stable only until acceptance.
- Region boundaries are inclusive, e.g. 0x03FFF is ROM, 0x04000 is RAM, 0xEFFFF is RAM, 0xF0000 is VRAM.
- Reset mid-cycle: at the next edge the strobes return high, the state returns to IDLE and rsp_valid=0. No response is issued for the aborted cycle.

Optional Feature:
- Macro: BUS_READY_EN.
- Defined:
  - Adds input port bus_ready (1 bit, active high).
  - In STROBE, once the wait counter has reached 0, the block stays in STROBE, with the strobe held low, until bus_ready=1.
  - Read data is captured on the cycle bus_ready=1 is sampled. bus_ready is ignored in every other state.
- Undefined: no such port exists. Strobe length is fixed at WS+1 cycles.

Test Plan:
- After rst, check every output at its reset value and req_ready=1.
  - Then read 0x04000 with bus_rdata=0xA5.
  - Expect bus_oe_n low for exactly 1 cycle, rsp_valid 4 cycles after accept, rsp_rdata=0xA5, rsp_err=0.
- Read 0x03FFF (ROM) with bus_rdata=0x3C -> bus_oe_n low for 3 cycles, rsp_rdata=0x3C at 6 cycles, bus_addr=0x03FFF throughout.
- Write 0x5A to 0xF0000 (VRAM) -> bus_we_n low for 2 cycles, bus_wdata=0x5A, bus_oe_n stays 1, rsp_valid at 5 cycles.
- Write to 0x00000 (ROM) -> no strobe at all, rsp_valid with rsp_err=1 one cycle after accept, req_ready back high the next cycle.
- Back-to-back requests to 0x3FFFF, 0x40000, 0xBFFFF, 0xC0000, 0xEFFFF, 0xFFFFF with req_valid held high.
  - Each is accepted only in IDLE.
  - Each uses the correct WS: 0,0,0,0,0,1 extra cycles.
- Assert rst during STROBE of a ROM read -> strobes high and state IDLE at the next edge, no rsp_valid, next request completes normally.

Source files
------------

// File: rtl/bus_cycle_master.sv
// Single-cycle bus initiator for the 20-bit system bus: ROM / RAM / VRAM regions with per-region wait states.
// Optional `BUS_READY_EN adds a bus_ready input that stretches the strobe once the wait count expires.
module bus_cycle_master #(
  parameter int ROM_WS  = 2,
  parameter int RAM_WS  = 0,
  parameter int VRAM_WS = 1,
  parameter int DW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [19:0]   req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic [19:0]   bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
`ifdef BUS_READY_EN
  input  logic          bus_ready,
`endif
  output logic          bus_oe_n,
  output logic          bus_we_n
);

  localparam int CW = 8;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] STROBE = 3'd2;
  localparam logic [2:0] HOLD   = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [19:0]   addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          oe_n_q, oe_n_d;
  logic          we_n_q, we_n_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  logic          is_rom;
  logic          is_vram;
  logic [CW-1:0] ws_sel;
  logic          strobe_done;

  // Region decode of the incoming address; it becomes bus_addr on the same edge.
  assign is_rom  = (req_addr <= 20'h03FFF);
  assign is_vram = (req_addr >= 20'hF0000);
  assign ws_sel  = is_rom  ? CW'(ROM_WS)  :
                   is_vram ? CW'(VRAM_WS) : CW'(RAM_WS);

`ifdef BUS_READY_EN
  assign strobe_done = bus_ready;
`else
  assign strobe_done = 1'b1;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          we_d    = req_we;
          cnt_d   = ws_sel;
          if (req_we && is_rom) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d = SETUP;
          end
        end
      end
      SETUP:  state_d = STROBE;
      STROBE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (strobe_done) begin
          if (!we_q) rdata_d = bus_rdata;
          state_d = HOLD;
        end
      end
      HOLD:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Strobes and the response flag are derived from the next state so they come straight off flops.
    oe_n_d  = !((state_d == STROBE) && !we_d);
    we_n_d  = !((state_d == STROBE) &&  we_d);
    valid_d = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_oe_n  = oe_n_q;
  assign bus_we_n  = we_n_q;

endmodule
